// File: rtl/ntt_pkg.sv
// ---------------------------------------------------------------------------
// ntt_pkg
// Shared constants and types for the NTT coefficient unload path.
//   DATA_WIDTH      coefficient width
//   ADDR_WIDTH      BRAM address width (32 entries per bank)
//   NUM_BRAM        number of coefficient banks
//   NUM_COEFFS      coefficients per polynomial
//   COEFFS_PER_WORD coefficients packed into one output word
//   unload_state_e  unload controller states
// ---------------------------------------------------------------------------
package ntt_pkg;

  localparam int DATA_WIDTH      = 12;
  localparam int ADDR_WIDTH      = 5;
  localparam int NUM_BRAM        = 8;
  localparam int NUM_COEFFS      = 256;
  localparam int COEFFS_PER_WORD = 16;
  localparam int NUM_WORDS       = NUM_COEFFS / COEFFS_PER_WORD;
  localparam int READS_PER_WORD  = COEFFS_PER_WORD / 2;
  localparam int WORD_CNT_WIDTH  = 4;
  localparam int RD_CNT_WIDTH    = 3;
  localparam int WAIT_CNT_WIDTH  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_HOLD,
    ST_DONE
  } unload_state_e;

endpackage

// File: rtl/ntt_rd_tag_pipe.sv
// ---------------------------------------------------------------------------
// ntt_rd_tag_pipe
// Carries a valid flag and the read-slot index alongside the BRAM read so the
// capture logic knows which coefficient slots the returning data belongs to.
//   clk_i, rst_ni  clock / asynchronous active-low reset
//   in_valid       a bank read is issued this cycle
//   in_tag         slot index k of that read
//   out_valid      read data for the tagged read is on rdata this cycle
//   out_tag        slot index k of the returning data
// ---------------------------------------------------------------------------
module ntt_rd_tag_pipe
  import ntt_pkg::*;
#(
  parameter int READ_LATE = 2,
  parameter int TAG_WIDTH = RD_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  output logic [TAG_WIDTH-1:0] out_tag
);

  logic [READ_LATE-1:0] valid_q;
  logic [TAG_WIDTH-1:0] tag_q [READ_LATE];

  // Reset clears every stage, so reads still in flight at reset are never
  // captured once the design comes back up.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < READ_LATE; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      tag_q[0]   <= in_tag;
      for (int i = 1; i < READ_LATE; i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[READ_LATE-1];
  assign out_tag   = tag_q[READ_LATE-1];

endmodule

// File: rtl/ntt_unload.sv
// ---------------------------------------------------------------------------
// ntt_unload
// Streams the 256 coefficients held across the BRAM banks out as 16 packed
// words of 16 coefficients each, coefficient 0 of a word in the MSBs.
//   clk_i, rst_ni          clock / asynchronous active-low reset
//   start, is_NTT          run request (IDLE only) and mode tag
//   re                     one-hot bank read enable
//   addr_rd_a, addr_rd_b   port A/B read addresses
//   rdata_a, rdata_b       bank read data, READ_LATE cycles after re
//   dout, valid_output     packed word and its valid
//   ready_output           sink accept
//   is_NTT_output          mode tag latched at start
//   busy, done_all         controller active / completion pulse
// ---------------------------------------------------------------------------
module ntt_unload #(
  parameter int DATA_WIDTH   = ntt_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH   = ntt_pkg::ADDR_WIDTH,
  parameter int OUTPUT_WIDTH = 192,
  parameter int NUM_BRAM     = ntt_pkg::NUM_BRAM,
  parameter int READ_LATE    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start,
  input  logic                    is_NTT,
  output logic [NUM_BRAM-1:0]     re,
  output logic [ADDR_WIDTH-1:0]   addr_rd_a,
  output logic [ADDR_WIDTH-1:0]   addr_rd_b,
  input  logic [DATA_WIDTH-1:0]   rdata_a,
  input  logic [DATA_WIDTH-1:0]   rdata_b,
  output logic [OUTPUT_WIDTH-1:0] dout,
  output logic                    valid_output,
  input  logic                    ready_output,
  output logic                    is_NTT_output,
  output logic                    busy,
  output logic                    done_all
);

  import ntt_pkg::*;

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LAST = WAIT_CNT_WIDTH'(READ_LATE - 1);
  localparam logic [WORD_CNT_WIDTH-1:0] LAST_WORD = WORD_CNT_WIDTH'(NUM_WORDS - 1);
  localparam logic [RD_CNT_WIDTH-1:0]   LAST_READ = RD_CNT_WIDTH'(READS_PER_WORD - 1);
  localparam logic [ADDR_WIDTH-1:0]     HALF_BANK = ADDR_WIDTH'(COEFFS_PER_WORD);

  unload_state_e              state_q, state_d;
  logic [WORD_CNT_WIDTH-1:0]  word_q;
  logic [RD_CNT_WIDTH-1:0]    rd_q;
  logic [WAIT_CNT_WIDTH-1:0]  wait_q;
  logic                       is_ntt_q;
  logic [ADDR_WIDTH-1:0]      addr_a_q, addr_b_q;
  logic [ADDR_WIDTH-1:0]      rd_base;
  logic [DATA_WIDTH-1:0]      coeff_q [COEFFS_PER_WORD];
  logic                       handshake;
  logic                       tag_valid;
  logic [RD_CNT_WIDTH-1:0]    tag_k;

  assign handshake = valid_output & ready_output;

  // Two words share each bank: even words take the lower half of the bank,
  // odd words the upper half.
  assign rd_base = word_q[0] ? HALF_BANK : '0;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: eight bank reads per word, then a drain of READ_LATE
  // cycles so the last read lands before the word is presented.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)                state_d = ST_READ;
      ST_READ: if (rd_q == LAST_READ)    state_d = ST_WAIT;
      ST_WAIT: if (wait_q == WAIT_LAST)  state_d = ST_HOLD;
      ST_HOLD: if (handshake)            state_d = (word_q == LAST_WORD) ? ST_DONE : ST_READ;
      ST_DONE:                           state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // Word / read / drain counters and the mode tag captured at start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q   <= '0;
      rd_q     <= '0;
      wait_q   <= '0;
      is_ntt_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            word_q   <= '0;
            rd_q     <= '0;
            is_ntt_q <= is_NTT;
          end
        end
        ST_READ: begin
          rd_q   <= rd_q + 1'b1;
          wait_q <= '0;
        end
        ST_WAIT: wait_q <= wait_q + 1'b1;
        ST_HOLD: begin
          if (handshake && (word_q != LAST_WORD)) begin
            word_q <= word_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic. Addresses are only recomputed while reading; otherwise
  // they replay the registered copy so the BRAM ports see a stable value.
  always_comb begin
    re           = '0;
    addr_rd_a    = addr_a_q;
    addr_rd_b    = addr_b_q;
    valid_output = 1'b0;
    busy         = (state_q != ST_IDLE);
    done_all     = 1'b0;
    case (state_q)
      ST_READ: begin
        re        = NUM_BRAM'(1) << word_q[WORD_CNT_WIDTH-1:1];
        addr_rd_a = rd_base + ADDR_WIDTH'({rd_q, 1'b0});
        addr_rd_b = rd_base + ADDR_WIDTH'({rd_q, 1'b1});
      end
      ST_HOLD: valid_output = 1'b1;
      ST_DONE: done_all     = 1'b1;
      default: ;
    endcase
  end

  // Last driven read addresses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_a_q <= '0;
      addr_b_q <= '0;
    end else begin
      addr_a_q <= addr_rd_a;
      addr_b_q <= addr_rd_b;
    end
  end

  ntt_rd_tag_pipe #(
    .READ_LATE (READ_LATE),
    .TAG_WIDTH (RD_CNT_WIDTH)
  ) u_tag_pipe (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_valid  (state_q == ST_READ),
    .in_tag    (rd_q),
    .out_valid (tag_valid),
    .out_tag   (tag_k)
  );

  // Read k returns coefficients 2k (port A) and 2k+1 (port B). All captures
  // for a word finish before HOLD, so the word is stable while presented.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < COEFFS_PER_WORD; j++) begin
        coeff_q[j] <= '0;
      end
    end else if (tag_valid) begin
      coeff_q[{tag_k, 1'b0}] <= rdata_a;
      coeff_q[{tag_k, 1'b1}] <= rdata_b;
    end
  end

  for (genvar j = 0; j < COEFFS_PER_WORD; j++) begin : g_pack
    assign dout[OUTPUT_WIDTH-DATA_WIDTH*(j+1) +: DATA_WIDTH] = coeff_q[j];
  end

  assign is_NTT_output = is_ntt_q;

endmodule

// File: tb/tb_ntt_unload.sv
// ---------------------------------------------------------------------------
// tb_ntt_unload
// Drives two ntt_unload instances (READ_LATE 2 and 4) from the same stimulus,
// each with its own BRAM model. Expected words are computed from the bank
// contents when a start is accepted and queued per instance; a negedge
// monitor pops and compares whenever an instance presents a word.
// ---------------------------------------------------------------------------
module tb_ntt_unload;

  localparam int DW  = 12;
  localparam int AW  = 5;
  localparam int OW  = 192;
  localparam int NB  = 8;
  localparam int RL0 = 2;
  localparam int RL1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start;
  logic is_ntt;
  logic ready;

  logic [NB-1:0] re       [2];
  logic [AW-1:0] addr_a   [2];
  logic [AW-1:0] addr_b   [2];
  logic [DW-1:0] rdata_a  [2];
  logic [DW-1:0] rdata_b  [2];
  logic [OW-1:0] dout     [2];
  logic          valid    [2];
  logic          ntt_out  [2];
  logic          busy     [2];
  logic          done_all [2];

  ntt_unload #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_WIDTH(OW), .NUM_BRAM(NB), .READ_LATE(RL0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start(start), .is_NTT(is_ntt),
    .re(re[0]), .addr_rd_a(addr_a[0]), .addr_rd_b(addr_b[0]),
    .rdata_a(rdata_a[0]), .rdata_b(rdata_b[0]),
    .dout(dout[0]), .valid_output(valid[0]), .ready_output(ready),
    .is_NTT_output(ntt_out[0]), .busy(busy[0]), .done_all(done_all[0])
  );

  ntt_unload #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_WIDTH(OW), .NUM_BRAM(NB), .READ_LATE(RL1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start(start), .is_NTT(is_ntt),
    .re(re[1]), .addr_rd_a(addr_a[1]), .addr_rd_b(addr_b[1]),
    .rdata_a(rdata_a[1]), .rdata_b(rdata_b[1]),
    .dout(dout[1]), .valid_output(valid[1]), .ready_output(ready),
    .is_NTT_output(ntt_out[1]), .busy(busy[1]), .done_all(done_all[1])
  );

  // Bank contents shared by both BRAM models.
  logic [DW-1:0] mem [NB][32];

  // Per-instance BRAM read pipelines; unselected cycles return noise.
  logic [DW-1:0] pa [2][4];
  logic [DW-1:0] pb [2][4];
  logic [DW-1:0] va, vb;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      va = DW'($urandom);
      vb = DW'($urandom);
      for (int b = 0; b < NB; b++) begin
        if (re[i] == (NB'(1) << b)) begin
          va = mem[b][addr_a[i]];
          vb = mem[b][addr_b[i]];
        end
      end
      for (int s = 3; s > 0; s--) begin
        pa[i][s] <= pa[i][s-1];
        pb[i][s] <= pb[i][s-1];
      end
      pa[i][0] <= va;
      pb[i][0] <= vb;
    end
  end

  assign rdata_a[0] = pa[0][RL0-1];
  assign rdata_b[0] = pb[0][RL0-1];
  assign rdata_a[1] = pa[1][RL1-1];
  assign rdata_b[1] = pb[1][RL1-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input int inst,
                             input logic [OW-1:0] act, input logic [OW-1:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s dut%0d cycle %0d: got %h required %h", name, inst, cyc, act, expv);
    end
  endtask

  function automatic int readLate(input int inst);
    return (inst == 0) ? RL0 : RL1;
  endfunction

  // Coefficient n of the polynomial lives in bank n/32 at address n%32;
  // word w carries coefficients 16w..16w+15, the first in the MSBs.
  function automatic logic [OW-1:0] refWord(input int w);
    logic [OW-1:0] r;
    int n;
    r = '0;
    for (int j = 0; j < 16; j++) begin
      n = w * 16 + j;
      r[OW-DW*(j+1) +: DW] = mem[n/32][n%32];
    end
    return r;
  endfunction

  // Scoreboard state per instance.
  logic [OW-1:0] exp_q [2][$];
  bit            exp_ntt    [2];
  bit            model_busy [2];
  bit            awaiting   [2];
  int            due        [2];
  int            done_due   [2];
  int            hs_count   [2];
  bit            accept;

  initial begin
    for (int i = 0; i < 2; i++) begin
      model_busy[i] = 1'b0;
      awaiting[i]   = 1'b0;
      done_due[i]   = -1;
      hs_count[i]   = 0;
    end
  end

  // Monitor: reset behaviour, word timing, content, hold stability and
  // completion, all judged against the queued expectations.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        checkOutput("rst_valid", i, OW'(valid[i]), '0);
        checkOutput("rst_re", i, OW'(re[i]), '0);
        checkOutput("rst_addr_a", i, OW'(addr_a[i]), '0);
        checkOutput("rst_addr_b", i, OW'(addr_b[i]), '0);
        checkOutput("rst_dout", i, dout[i], '0);
        checkOutput("rst_is_NTT_output", i, OW'(ntt_out[i]), '0);
        checkOutput("rst_busy", i, OW'(busy[i]), '0);
        checkOutput("rst_done_all", i, OW'(done_all[i]), '0);
        exp_q[i].delete();
        model_busy[i] = 1'b0;
        awaiting[i]   = 1'b0;
        done_due[i]   = -1;
      end else begin
        accept = start && !model_busy[i];
        checkOutput("busy", i, OW'(busy[i]), OW'(model_busy[i]));
        if (exp_q[i].size() == 0) begin
          checkOutput("valid_no_word", i, OW'(valid[i]), '0);
        end else if (valid[i]) begin
          if (awaiting[i]) begin
            checkOutput("valid_cycle", i, OW'(cyc), OW'(due[i]));
            awaiting[i] = 1'b0;
          end
          checkOutput("dout", i, dout[i], exp_q[i][0]);
          checkOutput("is_NTT_output", i, OW'(ntt_out[i]), OW'(exp_ntt[i]));
          checkOutput("re_in_hold", i, OW'(re[i]), '0);
          if (ready) begin
            void'(exp_q[i].pop_front());
            hs_count[i]++;
            if (exp_q[i].size() > 0) begin
              awaiting[i] = 1'b1;
              due[i]      = cyc + 9 + readLate(i);
            end else begin
              done_due[i] = cyc + 1;
            end
          end
        end else if (awaiting[i] && cyc > due[i]) begin
          checkOutput("valid_late", i, OW'(valid[i]), OW'(1));
          awaiting[i] = 1'b0;
        end
        if (done_due[i] == cyc) begin
          checkOutput("done_all", i, OW'(done_all[i]), OW'(1));
          done_due[i]   = -1;
          model_busy[i] = 1'b0;
        end else begin
          checkOutput("done_all_quiet", i, OW'(done_all[i]), '0);
        end
        if (accept) begin
          for (int w = 0; w < 16; w++) exp_q[i].push_back(refWord(w));
          exp_ntt[i]    = is_ntt;
          model_busy[i] = 1'b1;
          awaiting[i]   = 1'b1;
          due[i]        = cyc + 9 + readLate(i);
          hs_count[i]   = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit mode);
    start  = 1'b1;
    is_ntt = mode;
    tick();
    start  = 1'b0;
  endtask

  task automatic fillLinear();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 32; a++) mem[b][a] = DW'(b * 32 + a);
  endtask

  task automatic fillRandom();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 32; a++) mem[b][a] = DW'($urandom);
  endtask

  task automatic timeoutFail(input string name, input int got, input int required);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got %0d required %0d", name, got, required);
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while ((model_busy[0] || model_busy[1]) && n < budget) begin
      tick();
      n++;
    end
    if (model_busy[0] || model_busy[1]) begin
      timeoutFail("idle_timeout_cycles", n, budget);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
    end
  endtask

  task automatic waitHs(input int inst, input int count, input int budget);
    int n;
    n = 0;
    while (hs_count[inst] < count && n < budget) begin
      tick();
      n++;
    end
    if (hs_count[inst] < count) timeoutFail("handshake_count", hs_count[inst], count);
  endtask

  task automatic waitValid(input int inst, input int budget);
    int n;
    n = 0;
    while (!valid[inst] && n < budget) begin
      tick();
      n++;
    end
    if (!valid[inst]) timeoutFail("valid_wait_cycles", n, budget);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    is_ntt = 1'b0;
    ready  = 1'b1;
    fillLinear();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] run 1: linear banks, sink always ready");
    applyStimulus(1'b0);
    waitIdle(600);
    tick();

    $display("[TB] run 2: mode toggling, ignored start, sink stall at word 3");
    applyStimulus(1'b1);
    is_ntt = 1'b0;
    tick();
    is_ntt = 1'b1;
    tick();
    is_ntt = 1'b0;
    waitHs(0, 2, 200);
    tick();
    tick();
    start  = 1'b1;
    is_ntt = 1'b1;
    tick();
    start  = 1'b0;
    is_ntt = 1'b0;
    waitHs(0, 3, 200);
    waitValid(0, 50);
    ready = 1'b0;
    repeat (5) tick();
    ready = 1'b1;
    waitIdle(800);
    tick();

    $display("[TB] run 3: random banks, random sink readiness");
    fillRandom();
    applyStimulus(1'($urandom_range(0, 1)));
    for (int n = 0; n < 3000 && (model_busy[0] || model_busy[1]); n++) begin
      ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    ready = 1'b1;
    waitIdle(600);
    tick();

    $display("[TB] run 4: reset while word 7 is held, then restart");
    fillLinear();
    applyStimulus(1'b0);
    waitHs(0, 7, 300);
    waitValid(0, 50);
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b1);
    waitIdle(600);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time exhausted");
    $fatal(1, "[TB] watchdog");
  end

endmodule
